// File: rtl/snn_apb_csr.sv
// APB slave CSR block for the SNN core: control/threshold/leak registers,
// auto-incrementing indirect weight SRAM window, and core-done interrupt.
module snn_apb_csr #(
  parameter int          WAW    = 8,
  parameter int          WDW    = 8,
  parameter logic [31:0] ID_VAL = 32'h534E_4E01
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           psel,
  input  logic           penable,
  input  logic           pwrite,
  input  logic [15:0]    paddr,
  input  logic [31:0]    pwdata,
  output logic [31:0]    prdata,
  output logic           pready,
  output logic           core_en,
  output logic           core_clr,
  output logic [15:0]    thresh,
  output logic [7:0]     leak,
  input  logic           core_busy,
  input  logic           core_done,
  output logic           wmem_we,
  output logic           wmem_re,
  output logic [WAW-1:0] wmem_addr,
  output logic [WDW-1:0] wmem_wdata,
  input  logic [WDW-1:0] wmem_rdata,
  output logic           irq
);

  typedef enum logic {IDLE, RDWAIT} state_t;

  localparam logic [2:0] A_CTRL     = 3'd0;
  localparam logic [2:0] A_STATUS   = 3'd1;
  localparam logic [2:0] A_THRESH   = 3'd2;
  localparam logic [2:0] A_LEAK     = 3'd3;
  localparam logic [2:0] A_WADDR    = 3'd4;
  localparam logic [2:0] A_WDATA    = 3'd5;
  localparam logic [2:0] A_IRQ_STAT = 3'd6;
  localparam logic [2:0] A_ID       = 3'd7;

  state_t         state, state_nx;
  logic           irq_en;
  logic           irq_stat;
  logic [WAW-1:0] waddr;
  logic [2:0]     idx;
  logic           access;
  logic           commit, wr_commit, rd_commit;
  logic           win_hit;
  logic [31:0]    rd_word;
  logic [31:0]    waddr_ext;
  logic [31:0]    wdata_ext;
  logic           unused_ok;

  assign idx       = paddr[4:2];
  assign access    = psel & penable;
  // Reset forces pready high, so commit must also be gated to abort any access.
  assign commit    = access & pready & ~rst;
  assign wr_commit = commit & pwrite;
  assign rd_commit = commit & ~pwrite;
  assign win_hit   = (idx == A_WDATA);
  assign unused_ok = ^{paddr, pwdata};

  always_comb begin
    state_nx = state;
    pready   = 1'b1;
    wmem_re  = 1'b0;
    case (state)
      IDLE: begin
        if (access && !pwrite && win_hit) begin
          pready   = 1'b0;
          wmem_re  = 1'b1;
          state_nx = RDWAIT;
        end
      end
      RDWAIT: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (rst) begin
      pready  = 1'b1;
      wmem_re = 1'b0;
    end
  end

  always_comb begin
    waddr_ext = '0;
    waddr_ext[WAW-1:0] = waddr;
    wdata_ext = '0;
    wdata_ext[WDW-1:0] = wmem_rdata;
    rd_word = '0;
    case (idx)
      A_CTRL:     rd_word = {29'd0, irq_en, 1'b0, core_en};
      A_STATUS:   rd_word = {31'd0, core_busy};
      A_THRESH:   rd_word = {16'd0, thresh};
      A_LEAK:     rd_word = {24'd0, leak};
      A_WADDR:    rd_word = waddr_ext;
      A_WDATA:    rd_word = wdata_ext;
      A_IRQ_STAT: rd_word = {31'd0, irq_stat};
      A_ID:       rd_word = ID_VAL;
      default:    rd_word = '0;
    endcase
    prdata = rd_commit ? rd_word : '0;
  end

  assign wmem_we    = wr_commit & win_hit;
  assign wmem_addr  = waddr;
  assign wmem_wdata = pwdata[WDW-1:0];
  assign irq        = irq_stat & irq_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      core_en  <= 1'b0;
      irq_en   <= 1'b0;
      core_clr <= 1'b0;
      thresh   <= '0;
      leak     <= '0;
      waddr    <= '0;
      irq_stat <= 1'b0;
    end else begin
      state    <= state_nx;
      core_clr <= wr_commit && (idx == A_CTRL) && pwdata[1];
      if (wr_commit) begin
        case (idx)
          A_CTRL: begin
            core_en <= pwdata[0];
            irq_en  <= pwdata[2];
          end
          A_THRESH: thresh <= pwdata[15:0];
          A_LEAK:   leak   <= pwdata[7:0];
          default: ;
        endcase
      end
      if (wr_commit && idx == A_WADDR)
        waddr <= pwdata[WAW-1:0];
      else if (commit && win_hit)
        waddr <= waddr + 1'b1;
      // A done pulse in the same cycle as a clearing write keeps the bit set.
      if (core_done)
        irq_stat <= 1'b1;
      else if (wr_commit && idx == A_IRQ_STAT && pwdata[0])
        irq_stat <= 1'b0;
    end
  end

endmodule

// File: tb/tb_snn_apb_csr.sv
// Directed self-checking bench for snn_apb_csr with a behavioural weight SRAM.
module tb_snn_apb_csr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [15:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready;
  logic        core_en, core_clr, core_busy = 1'b0, core_done = 1'b0;
  logic [15:0] thresh;
  logic [7:0]  leak;
  logic        wmem_we, wmem_re;
  logic [7:0]  wmem_addr, wmem_wdata, wmem_rdata;
  logic        irq;

  logic [7:0]  mem [0:255];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  snn_apb_csr #(.WAW(8), .WDW(8), .ID_VAL(32'h534E_4E01)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .core_en(core_en), .core_clr(core_clr), .thresh(thresh), .leak(leak),
    .core_busy(core_busy), .core_done(core_done), .wmem_we(wmem_we),
    .wmem_re(wmem_re), .wmem_addr(wmem_addr), .wmem_wdata(wmem_wdata),
    .wmem_rdata(wmem_rdata), .irq(irq)
  );

  always @(posedge clk) begin
    if (wmem_we) mem[wmem_addr] <= wmem_wdata;
    if (wmem_re) wmem_rdata <= mem[wmem_addr];
  end

  task automatic apb_xfer(input logic wr, input logic [15:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output int waits);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0;
    rd = '0;
    forever begin
      @(negedge clk);
      if (pready) begin
        rd = prdata;
        break;
      end
      waits++;
      if (waits > 8) begin
        bad++;
        $display("FAIL bus_timeout: pready still %b after %0d waits, required 1", pready, waits);
        break;
      end
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic apb_write(input logic [15:0] a, input logic [31:0] d);
    logic [31:0] rd; int w;
    apb_xfer(1'b1, a, d, rd, w);
  endtask

  task automatic apb_read(input logic [15:0] a, output logic [31:0] rd, output int w);
    apb_xfer(1'b0, a, 32'h0, rd, w);
  endtask

  task automatic test_reset;
    logic [31:0] rd; int w;
    logic [15:0] addrs [4] = '{16'h00, 16'h08, 16'h0C, 16'h10};
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({pready, prdata, irq, core_en, core_clr, wmem_we, wmem_re} !== {1'b1, 32'h0, 5'b0}) begin
      bad++;
      $display("FAIL reset_outputs: pready=%b prdata=%h irq=%b en=%b clr=%b we=%b re=%b required 1/0/0/0/0/0/0",
               pready, prdata, irq, core_en, core_clr, wmem_we, wmem_re);
    end
    @(posedge clk); #1 rst = 1'b0;
    apb_read(16'h1C, rd, w);
    total++;
    if (rd !== 32'h534E_4E01 || w !== 0) begin
      bad++;
      $display("FAIL reset_id: data=%h waits=%0d required 534e4e01/0", rd, w);
    end
    foreach (addrs[i]) begin
      apb_read(addrs[i], rd, w);
      total++;
      if (rd !== 32'h0) begin
        bad++;
        $display("FAIL reset_reg_%h: got %h required 00000000", addrs[i], rd);
      end
    end
  endtask

  task automatic test_regs;
    logic [31:0] rd; int w;
    apb_write(16'h08, 32'hABCD_1234);
    apb_read(16'h08, rd, w);
    total++;
    if (rd !== 32'h0000_1234 || thresh !== 16'h1234) begin
      bad++;
      $display("FAIL thresh: read=%h port=%h required 00001234/1234", rd, thresh);
    end
    apb_write(16'h0C, 32'h0000_01A5);
    apb_read(16'h0C, rd, w);
    total++;
    if (rd !== 32'h0000_00A5 || leak !== 8'hA5) begin
      bad++;
      $display("FAIL leak: read=%h port=%h required 000000a5/a5", rd, leak);
    end
    apb_write(16'h04, 32'hFFFF_FFFF);
    apb_read(16'h04, rd, w);
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL status_ro_idle: got %h required 00000000", rd);
    end
    core_busy = 1'b1;
    apb_read(16'h24, rd, w);
    total++;
    if (rd !== 32'h1) begin
      bad++;
      $display("FAIL status_busy_alias: got %h required 00000001", rd);
    end
    core_busy = 1'b0;
    apb_write(16'h1C, 32'h0);
    apb_read(16'h1C, rd, w);
    total++;
    if (rd !== 32'h534E_4E01 || thresh !== 16'h1234) begin
      bad++;
      $display("FAIL id_ro: id=%h thresh=%h required 534e4e01/1234", rd, thresh);
    end
    @(negedge clk);
    total++;
    if (prdata !== 32'h0 || wmem_we !== 1'b0 || wmem_re !== 1'b0) begin
      bad++;
      $display("FAIL idle_bus: prdata=%h we=%b re=%b required 0/0/0", prdata, wmem_we, wmem_re);
    end
  endtask

  task automatic test_wdata_write;
    logic [31:0] rd; int w;
    logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
    logic [7:0] locs [3] = '{8'hFE, 8'hFF, 8'h00};
    apb_write(16'h10, 32'h0000_00FE);
    foreach (vals[i]) apb_write(16'h14, {24'hABCDEF, vals[i]});
    foreach (vals[i]) begin
      total++;
      if (mem[locs[i]] !== vals[i]) begin
        bad++;
        $display("FAIL wdata_write_%h: got %h required %h", locs[i], mem[locs[i]], vals[i]);
      end
    end
    apb_read(16'h10, rd, w);
    total++;
    if (rd !== 32'h1) begin
      bad++;
      $display("FAIL waddr_wrap: got %h required 00000001", rd);
    end
  endtask

  task automatic test_wdata_read;
    logic [31:0] rd; int w;
    apb_write(16'h10, 32'h0000_00FE);
    apb_read(16'h14, rd, w);
    total++;
    if (rd !== 32'h11 || w !== 1) begin
      bad++;
      $display("FAIL wdata_read0: data=%h waits=%0d required 00000011/1", rd, w);
    end
    apb_read(16'h14, rd, w);
    total++;
    if (rd !== 32'h22 || w !== 1) begin
      bad++;
      $display("FAIL wdata_read1: data=%h waits=%0d required 00000022/1", rd, w);
    end
    apb_read(16'h10, rd, w);
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL waddr_after_reads: got %h required 00000000", rd);
    end
  endtask

  task automatic test_irq;
    logic [31:0] rd; int w;
    apb_write(16'h00, 32'h4);
    @(posedge clk); #1 core_done = 1'b1;
    @(posedge clk); #1 core_done = 1'b0;
    total++;
    if (irq !== 1'b1) begin
      bad++;
      $display("FAIL irq_set: irq=%b required 1", irq);
    end
    // clearing write commits in the same cycle as a second done pulse
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h18; pwdata = 32'h1;
    @(posedge clk); #1;
    penable = 1'b1; core_done = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; core_done = 1'b0;
    apb_read(16'h18, rd, w);
    total++;
    if (rd !== 32'h1 || irq !== 1'b1) begin
      bad++;
      $display("FAIL irq_set_wins: stat=%h irq=%b required 00000001/1", rd, irq);
    end
    apb_write(16'h18, 32'h1);
    apb_read(16'h18, rd, w);
    total++;
    if (rd !== 32'h0 || irq !== 1'b0) begin
      bad++;
      $display("FAIL irq_clear: stat=%h irq=%b required 00000000/0", rd, irq);
    end
  endtask

  task automatic test_abort;
    logic [31:0] rd; int w;
    apb_write(16'h10, 32'h10);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h14;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    apb_read(16'h10, rd, w);
    total++;
    if (rd !== 32'h10) begin
      bad++;
      $display("FAIL psel_drop_waddr: got %h required 00000010", rd);
    end
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h14;
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk);
    total++;
    if (pready !== 1'b0 || wmem_re !== 1'b1) begin
      bad++;
      $display("FAIL rd_first_cycle: pready=%b re=%b required 0/1", pready, wmem_re);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    total++;
    if (pready !== 1'b1 || prdata !== 32'h0) begin
      bad++;
      $display("FAIL rst_in_rdwait: pready=%b prdata=%h required 1/00000000", pready, prdata);
    end
    @(posedge clk); #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    apb_read(16'h10, rd, w);
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL rst_waddr: got %h required 00000000", rd);
    end
    apb_write(16'h00, 32'h3);
    total++;
    if (core_en !== 1'b1 || core_clr !== 1'b1) begin
      bad++;
      $display("FAIL ctrl_clr_pulse: en=%b clr=%b required 1/1", core_en, core_clr);
    end
    @(posedge clk); #1;
    total++;
    if (core_clr !== 1'b0 || core_en !== 1'b1) begin
      bad++;
      $display("FAIL ctrl_clr_width: clr=%b en=%b required 0/1", core_clr, core_en);
    end
    apb_read(16'h00, rd, w);
    total++;
    if (rd !== 32'h1) begin
      bad++;
      $display("FAIL ctrl_readback: got %h required 00000001", rd);
    end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_wdata_write();
    test_wdata_read();
    test_irq();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
